// File: rtl/qs_buffer_array.sv
// qs_buffer_array: FIFO/LIFO word buffer with occupancy flags and burst read FSM.
// Define QS_BUFFER_ERR_FLAGS_EN for sticky overflow/underflow flags.
module qs_buffer_array #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_edge,
    input  logic              mode,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic              rd_burst,
    input  logic [AW:0]       burst_len,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              burst_busy,
    output logic              burst_done,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [AW:0]   ONE_C   = 1;
    localparam logic [AW-1:0] ONE_A   = 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr, top, waddr, raddr;
    logic [AW:0]       rem, rem_nxt, count_nxt;
    logic              mode_q, rd_req, rd_acc, wr_acc, done_nxt;

    assign full       = count == DEPTH_C;
    assign empty      = count == '0;
    assign burst_busy = state == BURST;
    assign top        = count[AW-1:0] - ONE_A;
    assign rd_req     = burst_busy | rd_en;
    assign rd_acc     = rd_req & ~empty;
    assign wr_acc     = wr_en & (~full | rd_acc);

    // A LIFO push+pop overwrites the popped slot in place.
    assign waddr = !mode_q ? wptr : (rd_acc ? top : count[AW-1:0]);
    assign raddr = mode_q ? top : rptr;

    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + ONE_C;
            2'b01:   count_nxt = count - ONE_C;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_burst && burst_len != '0) begin
                    state_nxt = BURST;
                    rem_nxt   = burst_len;
                end
            end
            BURST: begin
                if (rd_acc)
                    rem_nxt = rem - ONE_C;
                // Ends on last word, on draining the buffer, or on finding it empty.
                if (empty || (rd_acc && (rem == ONE_C || count_nxt == '0))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_edge) begin
            state      <= IDLE;
            rem        <= '0;
            count      <= '0;
            wptr       <= '0;
            rptr       <= '0;
            mode_q     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            rem        <= rem_nxt;
            count      <= count_nxt;
            burst_done <= done_nxt;
            data_valid <= rd_acc;
            if (rd_acc)
                data_out <= mem[raddr];
            if (empty && state == IDLE)
                mode_q <= mode;
            if (!mode_q && wr_acc)
                wptr <= wptr + ONE_A;
            if (!mode_q && rd_acc)
                rptr <= rptr + ONE_A;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst_edge)
            mem[waddr] <= data_in;
    end

`ifdef QS_BUFFER_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst_edge || err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc)
                overflow <= 1'b1;
            if (!burst_busy && rd_en && empty)
                underflow <= 1'b1;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
